// File: rtl/adbg_jsp_wb_host.sv
// Wishbone initiator that runs a 16550-style UART as a byte pipe.
// After reset it programs LCR, FCR and IER, then polls LSR at a fixed rate.
// Each poll either reads one received byte from RBR or writes one pending
// byte to THR. Every access is guarded by a cycle timeout. An access that
// ends in err or timeout is abandoned and sets a sticky fault flag.
module adbg_jsp_wb_host #(
  parameter int unsigned POLL_DIV = 16,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [7:0]  INIT_LCR = 8'h03
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  input  logic       wb_err_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       busy_o,
  output logic       fault_o
);

  localparam logic [15:0] DIV_LOAD = 16'(POLL_DIV - 1);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0]  LCR_VAL  = INIT_LCR & 8'h7F;  // DLAB never set

  localparam logic [2:0] ADR_RBR = 3'd0;  // RBR on read, THR on write
  localparam logic [2:0] ADR_IER = 3'd1;
  localparam logic [2:0] ADR_FCR = 3'd2;
  localparam logic [2:0] ADR_LCR = 3'd3;
  localparam logic [2:0] ADR_LSR = 3'd5;

  localparam logic [7:0] FCR_FLUSH = 8'h06;  // clear both FIFOs
  localparam logic [7:0] IER_NONE  = 8'h00;  // polled operation, no interrupts

  typedef enum logic [2:0] {
    ST_INIT_LCR,
    ST_INIT_FCR,
    ST_INIT_IER,
    ST_WAIT,
    ST_POLL,
    ST_RD_RBR,
    ST_WR_THR
  } state_t;

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [2:0]  adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [15:0] div_q, div_d;
  logic        fault_q, fault_d;
  logic        tx_full_q, tx_full_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;

  logic start;
  logic acc_ok;
  logic acc_abort;
  logic in_init;

  // err dominates a simultaneous ack; an ack on the last allowed cycle still counts
  assign acc_ok    = wb_ack_i & ~wb_err_i;
  assign acc_abort = wb_err_i | (~wb_ack_i & (tmo_q == TMO_LAST));
  assign in_init   = (state_q == ST_INIT_LCR) || (state_q == ST_INIT_FCR) ||
                     (state_q == ST_INIT_IER);

  // Next-state, bus launch/termination, byte holders and counters
  always_comb begin
    // NOTE: every variable written here gets its hold value first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    tmo_d      = tmo_q;
    div_d      = div_q;
    fault_d    = fault_q;
    tx_full_d  = tx_full_q;
    tx_byte_d  = tx_byte_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    start      = 1'b0;

    // Stream handshakes; neither can collide with the bus updates below
    // because THR is only written while the holder is full and RBR is only
    // read while the slot is empty.
    if (tx_valid_i && tx_ready_o) begin
      tx_full_d = 1'b1;
      tx_byte_d = tx_data_i;
    end
    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      ST_WAIT: begin
        if (div_q != 16'd0) begin
          div_d = div_q - 16'd1;
        end else if (!rx_valid_q || tx_full_q) begin
          // WAIT was already idle, so the poll can launch on the entry edge
          state_d = ST_POLL;
          start   = 1'b1;
        end
      end

      default: begin
        if (!cyc_q) begin
          // Entered from another access (or out of reset): this idle
          // cycle is the mandatory gap, launch now.
          start = 1'b1;
        end else if (acc_ok || acc_abort) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          adr_d = 3'd0;
          dat_d = 8'd0;
          if (acc_abort) begin
            fault_d = 1'b1;
            if (!in_init) begin
              // tx byte stays in the holder; RBR data is simply not captured
              state_d = ST_WAIT;
              div_d   = DIV_LOAD;
            end
            // an aborted init step stays put and is relaunched after the gap
          end else begin
            case (state_q)
              ST_INIT_LCR: state_d = ST_INIT_FCR;
              ST_INIT_FCR: state_d = ST_INIT_IER;
              ST_POLL: begin
                // rx has priority; a pending tx byte is served on a later poll
                if (wb_dat_i[0] && !rx_valid_q) begin
                  state_d = ST_RD_RBR;
                end else if (wb_dat_i[5] && tx_full_q) begin
                  state_d = ST_WR_THR;
                end else begin
                  state_d = ST_WAIT;
                  div_d   = DIV_LOAD;
                end
              end
              ST_RD_RBR: begin
                rx_valid_d = 1'b1;
                rx_data_d  = wb_dat_i;
                state_d    = ST_WAIT;
                div_d      = DIV_LOAD;
              end
              ST_WR_THR: begin
                tx_full_d = 1'b0;
                state_d   = ST_WAIT;
                div_d     = DIV_LOAD;
              end
              default: begin  // ST_INIT_IER
                state_d = ST_WAIT;
                div_d   = DIV_LOAD;
              end
            endcase
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
    endcase

    // Launch the access belonging to the state being (re)entered
    if (start) begin
      cyc_d = 1'b1;
      tmo_d = 8'd0;
      case (state_d)
        ST_INIT_LCR: begin we_d = 1'b1; adr_d = ADR_LCR; dat_d = LCR_VAL;   end
        ST_INIT_FCR: begin we_d = 1'b1; adr_d = ADR_FCR; dat_d = FCR_FLUSH; end
        ST_INIT_IER: begin we_d = 1'b1; adr_d = ADR_IER; dat_d = IER_NONE;  end
        ST_POLL:     begin we_d = 1'b0; adr_d = ADR_LSR; dat_d = 8'd0;      end
        ST_RD_RBR:   begin we_d = 1'b0; adr_d = ADR_RBR; dat_d = 8'd0;      end
        ST_WR_THR:   begin we_d = 1'b1; adr_d = ADR_RBR; dat_d = tx_byte_q; end
        default:     begin cyc_d = 1'b0; we_d = 1'b0; adr_d = 3'd0; dat_d = 8'd0; end
      endcase
    end
  end

  // State and all bus/stream registers; reset drops the bus at once
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_INIT_LCR;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= 3'd0;
      dat_q      <= 8'd0;
      tmo_q      <= 8'd0;
      div_q      <= 16'd0;
      fault_q    <= 1'b0;
      tx_full_q  <= 1'b0;
      tx_byte_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values
      // the combinational block computed from.
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      tmo_q      <= tmo_d;
      div_q      <= div_d;
      fault_q    <= fault_d;
      tx_full_q  <= tx_full_d;
      tx_byte_q  <= tx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign busy_o     = cyc_q;
  assign fault_o    = fault_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  // holder is not offered while reset is held
  assign tx_ready_o = ~tx_full_q & ~wb_rst_i;

endmodule

// File: tb/tb_adbg_jsp_wb_host.sv
// Self-checking bench for adbg_jsp_wb_host: a Wishbone UART target model
// logs every completed access; the expected access sequence is derived
// from LSR contents and the rx/tx occupancy tracked by the bench.
module tb_adbg_jsp_wb_host;

  localparam int         POLL_DIV = 4;
  localparam int         TIMEOUT  = 255;
  localparam logic [7:0] INIT_LCR = 8'h83;

  logic       wb_clk_i;
  logic       wb_rst_i;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i, wb_err_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       busy_o;
  logic       fault_o;

  adbg_jsp_wb_host #(
    .POLL_DIV (POLL_DIV),
    .TIMEOUT  (TIMEOUT),
    .INIT_LCR (INIT_LCR)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .busy_o     (busy_o),
    .fault_o    (fault_o)
  );

  typedef struct packed {
    logic       we;
    logic [2:0] adr;
    logic [7:0] dat;
  } acc_t;

  acc_t log_q[$];
  acc_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // target model controls
  logic [7:0] lsr_val = 8'h00;
  logic [7:0] rbr_val = 8'h00;
  bit         hang_thr = 0;
  bit         err_thr  = 0;
  int         err_cnt  = 0;

  // monitor results
  int  low_run = 0, high_run = 0, last_gap = 0, last_high = 0;
  int  thr_drops = 0, proto_bad = 0;
  bit  prev_cyc = 0, prev_thr = 0;
  logic [11:0] prev_bus = '0;

  // bench model of the byte holders
  bit         m_rx_full = 0;
  logic [7:0] m_rx_data = 8'h00;
  bit         m_tx_full = 0;
  logic [7:0] m_tx_byte = 8'h00;

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Target: random 1..3 cycle latency, logs each successful access
  initial begin
    int seen;
    int lat;
    seen = 0;
    lat  = 0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 8'h00;
    forever begin
      @(posedge wb_clk_i); #1;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 8'h00;
      if (!wb_cyc_o) begin
        seen = 0;
      end else begin
        if (seen == 0) lat = $urandom_range(0, 2);
        if (seen >= lat && !(hang_thr && wb_we_o && wb_adr_o == 3'd0)) begin
          if (err_thr && wb_we_o && wb_adr_o == 3'd0) begin
            wb_ack_i = 1'b1;
            wb_err_i = 1'b1;
            err_cnt++;
          end else begin
            wb_ack_i = 1'b1;
            if (!wb_we_o) wb_dat_i = (wb_adr_o == 3'd5) ? lsr_val :
                                     (wb_adr_o == 3'd0) ? rbr_val : 8'h00;
            log_q.push_back({wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : wb_dat_i});
          end
        end
        seen++;
      end
    end
  end

  // Monitor: bus protocol rules and run lengths of cyc high / low
  initial begin
    forever begin
      @(posedge wb_clk_i); #1;
      if (wb_stb_o !== wb_cyc_o || busy_o !== wb_cyc_o) proto_bad++;
      if (wb_cyc_o && !wb_we_o && wb_dat_o !== 8'h00) proto_bad++;
      if (wb_cyc_o && prev_cyc && {wb_we_o, wb_adr_o, wb_dat_o} !== prev_bus) proto_bad++;
      if (wb_cyc_o) begin
        if (!prev_cyc) last_gap = low_run;
        low_run  = 0;
        high_run++;
        prev_thr = wb_we_o && wb_adr_o == 3'd0;
      end else begin
        if (prev_cyc) begin
          last_high = high_run;
          if (prev_thr) thr_drops++;
        end
        high_run = 0;
        low_run++;
      end
      prev_cyc = wb_cyc_o;
      prev_bus = {wb_we_o, wb_adr_o, wb_dat_o};
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge wb_clk_i);
    #2;
  endtask

  task automatic wait_log(input int n, input string tag);
    int k;
    k = 0;
    while (log_q.size() < n && k < 3000) begin
      @(posedge wb_clk_i); #2;
      k++;
    end
    check(tag, 32'(log_q.size() >= n), 32'd1);
  endtask

  // change LSR only while no access is open, so every later poll sees it
  task automatic set_lsr(input logic [7:0] v);
    int k;
    k = 0;
    while (wb_cyc_o && k < 3000) begin
      @(posedge wb_clk_i); #2;
      k++;
    end
    lsr_val = v;
  endtask

  task automatic push_byte(input logic [7:0] b);
    check("tx_ready_empty", 32'(tx_ready_o), 32'd1);
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    @(posedge wb_clk_i); #2;
    tx_valid_i = 1'b0;
    m_tx_full = 1;
    m_tx_byte = b;
    check("tx_ready_full", 32'(tx_ready_o), 32'd0);
  endtask

  // wait for the first non-poll access after index base; it must be the THR write
  task automatic expect_write(input int base, input logic [7:0] b, input string tag);
    int   k;
    int   idx;
    bit   found;
    acc_t e;
    k = 0;
    idx = base;
    found = 0;
    e = '0;
    while (!found && k < 3000) begin
      if (idx < log_q.size()) begin
        e = log_q[idx];
        idx++;
        if (e.we || e.adr != 3'd5) found = 1;
      end else begin
        @(posedge wb_clk_i); #2;
        k++;
      end
    end
    check(tag, 32'(e), 32'({1'b1, 3'd0, b}));
  endtask

  // One scenario: optional push / consume under a neutral LSR, then a new
  // LSR value and the access sequence the rules predict from it.
  task automatic run_iter(input bit do_push, input logic [7:0] pb, input bit do_cons,
                          input logic [7:0] lv, input logic [7:0] rv);
    int base;
    bit rxf;
    bit txf;
    bit nopoll;
    set_lsr(8'h00);
    if (do_push && !m_tx_full) push_byte(pb);
    if (do_cons && m_rx_full) begin
      check("rx_held", 32'({rx_valid_o, rx_data_o}), 32'({1'b1, m_rx_data}));
      rx_ready_i = 1'b1;
      @(posedge wb_clk_i); #2;
      rx_ready_i = 1'b0;
      m_rx_full = 0;
      check("rx_valid_drop", 32'(rx_valid_o), 32'd0);
    end
    rbr_val = rv;
    set_lsr(lv);
    base = log_q.size();

    rxf = m_rx_full;
    txf = m_tx_full;
    nopoll = 0;
    exp_q.delete();
    for (int s = 0; s < 4; s++) begin
      if (rxf && !txf) begin
        nopoll = 1;
        break;
      end
      exp_q.push_back({1'b0, 3'd5, lv});
      if (lv[0] && !rxf) begin
        exp_q.push_back({1'b0, 3'd0, rv});
        rxf = 1;
        m_rx_data = rv;
      end else if (lv[5] && txf) begin
        exp_q.push_back({1'b1, 3'd0, m_tx_byte});
        txf = 0;
      end else begin
        break;
      end
    end
    m_rx_full = rxf;
    m_tx_full = txf;

    wait_log(base + exp_q.size(), "access_count");
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < log_q.size()) check("access", 32'(log_q[base + i]), 32'(exp_q[i]));
    end
    if (nopoll) begin
      wait_cycles(8 * POLL_DIV);
      check("no_poll", 32'(log_q.size()), 32'(base + exp_q.size()));
    end else begin
      wait_cycles(3);
    end
    check("rx_valid", 32'(rx_valid_o), 32'(m_rx_full));
    if (m_rx_full) check("rx_data", 32'(rx_data_o), 32'(m_rx_data));
    check("tx_ready", 32'(tx_ready_o), 32'(!m_tx_full));
  endtask

  initial begin
    int base;
    int d0;
    int k;
    logic [7:0] b;
    wb_rst_i   = 1'b1;
    tx_data_i  = 8'h99;
    tx_valid_i = 1'b1;
    rx_ready_i = 1'b0;

    // reset state, with a byte offered that must not be taken
    repeat (2) @(posedge wb_clk_i);
    #2;
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_bus", 32'({wb_we_o, wb_adr_o, wb_dat_o}), 32'd0);
    check("rst_tx_ready", 32'(tx_ready_o), 32'd0);
    check("rst_rx", 32'({rx_valid_o, rx_data_o}), 32'd0);
    check("rst_fault", 32'(fault_o), 32'd0);
    tx_valid_i = 1'b0;
    wb_rst_i   = 1'b0;
    #1;
    check("tx_ready_after_rst", 32'(tx_ready_o), 32'd1);

    // init writes, DLAB bit of INIT_LCR cleared, then polling
    wait_log(5, "init_count");
    if (log_q.size() >= 5) begin
      check("init_lcr", 32'(log_q[0]), 32'({1'b1, 3'd3, 8'h03}));
      check("init_fcr", 32'(log_q[1]), 32'({1'b1, 3'd2, 8'h06}));
      check("init_ier", 32'(log_q[2]), 32'({1'b1, 3'd1, 8'h00}));
      check("first_poll", 32'(log_q[3]), 32'({1'b0, 3'd5, 8'h00}));
      check("second_poll", 32'(log_q[4]), 32'({1'b0, 3'd5, 8'h00}));
    end
    check("poll_gap", 32'(last_gap), 32'(POLL_DIV));

    // directed: tx write, rx-before-tx priority, held rx slot
    run_iter(1, 8'h41, 0, 8'h20, 8'h00);
    run_iter(1, 8'h55, 0, 8'h21, 8'h7E);
    run_iter(0, 8'h00, 0, 8'h01, 8'h33);
    run_iter(1, 8'h5A, 0, 8'h01, 8'h34);
    run_iter(0, 8'h00, 1, 8'h21, 8'h44);

    // randomized scenarios
    for (int i = 0; i < 20; i++) begin
      run_iter(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
               8'($urandom), 8'($urandom));
    end

    // empty both holders
    run_iter(0, 8'h00, 1, 8'h20, 8'h00);
    check("fault_clean", 32'(fault_o), 32'd0);

    // ack+err on THR counts as err: byte kept, fault set, retried later
    set_lsr(8'h00);
    err_thr = 1;
    b = 8'($urandom);
    push_byte(b);
    set_lsr(8'h20);
    k = 0;
    while (err_cnt == 0 && k < 3000) begin
      @(posedge wb_clk_i); #2;
      k++;
    end
    wait_cycles(1);
    check("err_fault", 32'(fault_o), 32'd1);
    check("err_tx_kept", 32'(tx_ready_o), 32'd0);
    err_thr = 0;
    base = log_q.size();
    expect_write(base, b, "err_retry");
    m_tx_full = 0;
    wait_cycles(3);
    check("err_tx_done", 32'(tx_ready_o), 32'd1);

    // unanswered THR write is abandoned after TIMEOUT cycles and retried
    set_lsr(8'h00);
    hang_thr = 1;
    b = 8'($urandom);
    push_byte(b);
    d0 = thr_drops;
    set_lsr(8'h20);
    k = 0;
    while (thr_drops == d0 && k < 3000) begin
      @(posedge wb_clk_i); #2;
      k++;
    end
    check("tmo_length", 32'(last_high), 32'(TIMEOUT));
    check("tmo_fault", 32'(fault_o), 32'd1);
    check("tmo_tx_kept", 32'(tx_ready_o), 32'd0);
    hang_thr = 0;
    base = log_q.size();
    expect_write(base, b, "tmo_retry");
    m_tx_full = 0;

    // reset in the middle of a THR write
    set_lsr(8'h00);
    hang_thr = 1;
    push_byte(8'($urandom));
    set_lsr(8'h20);
    k = 0;
    while (!(wb_cyc_o && wb_we_o && wb_adr_o == 3'd0) && k < 3000) begin
      @(posedge wb_clk_i); #2;
      k++;
    end
    check("thr_in_flight", 32'(wb_cyc_o && wb_we_o && wb_adr_o == 3'd0), 32'd1);
    #3;
    wb_rst_i = 1'b1;
    #1;
    check("rst_mid_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_mid_tx", 32'(tx_ready_o), 32'd0);
    hang_thr = 0;
    lsr_val  = 8'h00;
    @(posedge wb_clk_i); #2;
    check("rst_mid_fault", 32'(fault_o), 32'd0);
    base = log_q.size();
    wb_rst_i = 1'b0;
    m_tx_full = 0;
    m_rx_full = 0;
    #1;
    check("rst_mid_tx_empty", 32'(tx_ready_o), 32'd1);
    wait_log(base + 3, "reinit_count");
    if (log_q.size() >= base + 3) begin
      check("reinit_lcr", 32'(log_q[base]),     32'({1'b1, 3'd3, 8'h03}));
      check("reinit_fcr", 32'(log_q[base + 1]), 32'({1'b1, 3'd2, 8'h06}));
      check("reinit_ier", 32'(log_q[base + 2]), 32'({1'b1, 3'd1, 8'h00}));
    end

    run_iter(1, 8'hC3, 0, 8'h21, 8'h18);

    check("protocol", 32'(proto_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
